// File: rtl/tx_buffer.sv
// Sequence buffer feeding a UART transmitter: stores up to NUM_SEQ sorted sequences,
// then serialises them byte by byte (LSB first) under a valid/ready handshake when flushed.
module tx_buffer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_SEQ = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] array_in [DEPTH],
  output logic             in_ready,
  input  logic             flush,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             tx_done,
  output logic             overflow
);

  localparam int BYTES = WIDTH / 8;
  localparam int CW    = $clog2(NUM_SEQ + 1);
  localparam int SW    = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
  localparam int EW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CW-1:0] NUM_SEQ_C = CW'(NUM_SEQ);
  localparam logic [EW-1:0] E_LAST    = EW'(DEPTH - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(BYTES - 1);

  typedef enum logic [1:0] {
    LOADING,
    SENDING,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   seq_count_q, seq_count_d;
  logic [SW-1:0]   s_q, s_d;
  logic [EW-1:0]   e_q, e_d;
  logic [BW-1:0]   b_q, b_d;
  logic            overflow_q, overflow_d;
  logic            wr_en;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] mem_q [NUM_SEQ][DEPTH];

  always_comb begin
    state_d     = state_q;
    seq_count_d = seq_count_q;
    s_d         = s_q;
    e_d         = e_q;
    b_d         = b_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;
    unique case (state_q)
      LOADING: begin
        if (valid_in) begin
          if (seq_count_q < NUM_SEQ_C) begin
            wr_en       = 1'b1;
            seq_count_d = seq_count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Decide on the post-store count so a same-cycle sequence is transmitted too.
        if (flush) begin
          state_d = (seq_count_d != '0) ? SENDING : DONE;
        end
      end
      SENDING: begin
        if (byte_ready) begin
          if (b_q == B_LAST) begin
            b_d = '0;
            if (e_q == E_LAST) begin
              e_d = '0;
              if (CW'(s_q) == seq_count_q - CW'(1)) begin
                state_d = DONE;
              end else begin
                s_d = s_q + SW'(1);
              end
            end else begin
              e_d = e_q + EW'(1);
            end
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      DONE: begin
        seq_count_d = '0;
        s_d         = '0;
        e_d         = '0;
        b_d         = '0;
        state_d     = LOADING;
      end
      default: state_d = LOADING;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOADING;
      seq_count_q <= '0;
      s_q         <= '0;
      e_q         <= '0;
      b_q         <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_count_q <= seq_count_d;
      s_q         <= s_d;
      e_q         <= e_d;
      b_q         <= b_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[seq_count_q[SW-1:0]][i] <= array_in[i];
      end
    end
  end

  always_comb begin
    word       = mem_q[s_q][e_q];
    byte_valid = (state_q == SENDING);
    byte_out   = byte_valid ? 8'(word >> {b_q, 3'b000}) : '0;
    tx_done    = (state_q == DONE);
    in_ready   = (state_q == LOADING) && (seq_count_q < NUM_SEQ_C);
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_tx_buffer.sv
// Self-checking bench for tx_buffer: table of load/flush scenarios plus hand sequences,
// with expected bytes queued at load time and popped on every handshake transfer.
module tb_tx_buffer;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int NUM_SEQ = 10;
  localparam int SEQ_BYTES = DEPTH * WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [WIDTH-1:0] array_in [DEPTH];
  logic             in_ready;
  logic             flush;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             tx_done;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];

  typedef struct {
    int nload;
    int pattern;   // 0: ready always 1, 1: ready 1-0-0-1 repeating
    int exp_bytes;
    int exp_ovf;
  } vec_t;

  vec_t vecs [4];

  tx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_SEQ(NUM_SEQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .array_in   (array_in),
    .in_ready   (in_ready),
    .flush      (flush),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx_done    (tx_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bval(input int k, input int e, input int b);
    return 8'(k * 37 + e * 4 + b);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    valid_in   = 1'b0;
    flush      = 1'b0;
    byte_ready = 1'b0;
    sb.delete();
    #1;
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);
  endtask

  task automatic load_seq(input int k, input bit with_flush);
    @(negedge clk);
    check("in_ready_load", in_ready, (k < NUM_SEQ) ? 1 : 0);
    valid_in = 1'b1;
    flush    = with_flush;
    for (int e = 0; e < DEPTH; e++)
      for (int b = 0; b < WIDTH / 8; b++)
        array_in[e][8*b +: 8] = bval(k, e, b);
    if (k < NUM_SEQ)
      for (int e = 0; e < DEPTH; e++)
        for (int b = 0; b < WIDTH / 8; b++)
          sb.push_back(bval(k, e, b));
  endtask

  task automatic start_flush();
    @(negedge clk);
    valid_in = 1'b0;
    flush    = 1'b1;
  endtask

  task automatic drain(input int exp_bytes, input int pattern);
    int   cyc = 0;
    int   xfers = 0;
    int   valid_cycles = 0;
    bit   done_seen = 0;
    bit   stalled = 0;
    logic [7:0] held = '0;
    logic [7:0] exp_b;
    while (!done_seen && cyc < 2000) begin
      @(negedge clk);
      valid_in = 1'b0;
      flush    = 1'b0;
      if (tx_done) begin
        done_seen = 1;
        check("byte_valid_in_done", byte_valid, 0);
      end else begin
        check("byte_valid_sending", byte_valid, 1);
        check("in_ready_sending", in_ready, 0);
        if (stalled) check("byte_held_stall", byte_out, held);
        byte_ready = (pattern == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        if (byte_valid) valid_cycles++;
        if (byte_valid && byte_ready) begin
          if (sb.size() == 0) begin
            check("extra_byte", 1, 0);
          end else begin
            exp_b = sb.pop_front();
            check("byte_out", byte_out, exp_b);
          end
          xfers++;
          stalled = 0;
        end else begin
          stalled = byte_valid;
          held    = byte_out;
        end
        // Inputs during transmission must be ignored.
        valid_in = 1'b1;
        for (int e = 0; e < DEPTH; e++) array_in[e] = 32'hEEEE_EEEE;
      end
      cyc++;
    end
    check("tx_done_seen", done_seen, 1);
    check("byte_count", xfers, exp_bytes);
    check("scoreboard_empty", sb.size(), 0);
    if (pattern == 0) begin
      check("back_to_back", valid_cycles, exp_bytes);
      check("done_latency", cyc, exp_bytes + 1);
    end
    @(negedge clk);
    valid_in   = 1'b0;
    byte_ready = 1'b0;
    check("tx_done_one_cycle", tx_done, 0);
    check("idle_byte_valid", byte_valid, 0);
    check("in_ready_reloaded", in_ready, 1);
  endtask

  initial begin
    rst        = 1'b1;
    valid_in   = 1'b0;
    flush      = 1'b0;
    byte_ready = 1'b0;
    for (int e = 0; e < DEPTH; e++) array_in[e] = '0;

    vecs[0] = '{nload: 1,  pattern: 0, exp_bytes: SEQ_BYTES,      exp_ovf: 0};
    vecs[1] = '{nload: 2,  pattern: 1, exp_bytes: 2 * SEQ_BYTES,  exp_ovf: 0};
    vecs[2] = '{nload: 11, pattern: 0, exp_bytes: 10 * SEQ_BYTES, exp_ovf: 1};
    vecs[3] = '{nload: 0,  pattern: 0, exp_bytes: 0,              exp_ovf: 0};

    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].nload; k++) load_seq(k, 1'b0);
      start_flush();
      drain(vecs[v].exp_bytes, vecs[v].pattern);
      check("overflow_sticky", overflow, vecs[v].exp_ovf);
    end

    // Sequence and flush in the same cycle with nothing stored.
    do_reset();
    load_seq(3, 1'b1);
    drain(SEQ_BYTES, 0);
    check("overflow_same_cycle", overflow, 0);

    // Reset in the middle of a 64-byte transmission.
    do_reset();
    load_seq(0, 1'b0);
    load_seq(1, 1'b0);
    start_flush();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      flush      = 1'b0;
      byte_ready = 1'b1;
      check("pre_rst_valid", byte_valid, 1);
      if (sb.size() != 0) check("pre_rst_byte", byte_out, sb.pop_front());
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_byte_valid", byte_valid, 0);
    check("async_rst_byte_out", byte_out, 0);
    check("async_rst_tx_done", tx_done, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready_after_mid_rst", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_valid_after_rst", byte_valid, 0);
    end
    load_seq(5, 1'b0);
    start_flush();
    drain(SEQ_BYTES, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_buffer.md
TX_BUFFER -- requirements
Module: tx_buffer

Interface
REQ-001 Parameter WIDTH, default 32: bits per array element.
REQ-002 Parameter DEPTH, default 8: elements per sequence.
REQ-003 Parameter NUM_SEQ, default 10: sequence storage capacity.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-006 valid_in  input  1  array_in holds a complete sequence this cycle.
REQ-007 array_in  input  [WIDTH-1:0] x DEPTH  sorted sequence, element 0 first.
REQ-008 in_ready  output  1  block accepts a sequence this cycle.
REQ-009 flush  input  1  start serialising all stored sequences.
REQ-010 byte_out  output  8  byte presented to the UART transmitter.
REQ-011 byte_valid  output  1  byte_out is valid.
REQ-012 byte_ready  input  1  UART transmitter accepts byte_out this cycle.
REQ-013 tx_done  output  1  one-cycle pulse: all stored bytes sent.
REQ-014 overflow  output  1  sticky: a sequence was dropped because storage was full.

Function
REQ-015 FSM states SHALL be LOADING, SENDING and DONE.
REQ-016 LOADING: a sequence is written into slot seq_count when valid_in && in_ready, then seq_count increments; seq_count width is clog2(NUM_SEQ+1).
REQ-017 in_ready SHALL be 1 only in LOADING with seq_count < NUM_SEQ.
REQ-018 valid_in while seq_count == NUM_SEQ: sequence dropped, overflow set to 1, held until reset.
REQ-019 valid_in outside LOADING: ignored; overflow unchanged.
REQ-020 flush in LOADING with seq_count > 0: next state SENDING; flush outside LOADING ignored.
REQ-021 flush in LOADING with seq_count == 0: next state DONE, no bytes emitted.
REQ-022 valid_in and flush in the same LOADING cycle: the sequence is stored, subject to REQ-018, and included in the transmission.
REQ-023 SENDING: byte_valid = 1 from the first SENDING cycle; byte_out = slot[s].element[e][8*b +: 8], counters s, e, b start at 0.
REQ-024 Byte order: b 0..3 (LSB first, WIDTH/8 bytes) inside element, e 0..DEPTH-1 inside slot, s 0..seq_count-1; total seq_count*DEPTH*WIDTH/8 bytes.
REQ-025 Handshake: a byte transfers on a cycle with byte_valid && byte_ready; counters advance only then; byte_out and byte_valid held stable while byte_ready == 0.
REQ-026 byte_valid SHALL never deassert in SENDING before a transfer; back-to-back transfers on consecutive cycles SHALL be sustained when byte_ready stays 1.
REQ-027 Transfer of the last byte: next state DONE; byte_valid = 0 in DONE.
REQ-028 DONE lasts exactly one cycle with tx_done = 1; seq_count, s, e, b cleared; next state LOADING.
REQ-029 byte_out SHALL be driven from registered storage, not array_in; storage contents after DONE are don't-care.

Reset
REQ-030 Asserting rst SHALL, without waiting for clk, force: state LOADING, seq_count/s/e/b = 0, byte_valid = 0, byte_out = 0, tx_done = 0, overflow = 0.
REQ-031 Reset mid-SENDING: the partial transmission is abandoned; no byte_valid after rst deasserts until a new flush.
REQ-032 Storage array contents need not be reset.
REQ-033 in_ready = 1 on the first cycle after rst deasserts.

Verification
REQ-034 Load 1 sequence {0x03020100,0x07060504,...,0x1F1E1D1C}, flush, byte_ready = 1 -> 32 consecutive byte_valid cycles, bytes 0x00..0x1F in order, then tx_done for 1 cycle.
REQ-035 Load 2 sequences, flush, byte_ready toggled 1-0-0-1 repeating -> 64 bytes, each held stable while stalled, no duplicates or skips; tx_done once.
REQ-036 Load 10 sequences, then an 11th valid_in -> in_ready = 0, overflow = 1; flush -> exactly 320 bytes from the first 10 sequences.
REQ-037 flush with nothing loaded -> tx_done on the next cycle, byte_valid never 1.
REQ-038 valid_in and flush in the same cycle with 0 loaded -> 32 bytes of that sequence are sent.
REQ-039 Assert rst after byte 5 of 64 -> outputs zero immediately; reload 1 sequence, flush -> 32 bytes starting at that sequence's byte 0.
